wb_regfile: RTL

Writeback stage and architectural register file for the 5-stage RV32I pipeline. Consumes the MEM/WB pipeline register outputs, selects the writeback result, commits it to a 32-entry integer register file, and serves the decode stage's two read ports with same-cycle write-through bypass. Also maintains a 64-bit retired-instruction counter and a debug read port for the testbench/trace.

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/regfile_array.sv | 68 ++++++
 rtl/wb_regfile.sv | 106 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: writeback result-select values and the hard-wired zero register index.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_RSV = 2'b11
  } result_src_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_array.sv
// Integer register storage: one write port, three combinational read ports, synchronous clear.
// Entry 0 is held at zero and every read of address 0 returns zero.
module regfile_array
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  input  logic [ADDR_WIDTH-1:0] raddr3,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic [DATA_WIDTH-1:0] rdata3
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  // Next array state: clear wins over the write, and x0 is never written.
  always_comb begin
    regs_d = regs_q;
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_d[i] = '0;
      end
    end else if (we && (waddr != REG_ZERO)) begin
      regs_d[waddr] = wdata;
    end else begin
      regs_d = regs_q;
    end
    regs_d[0] = '0;
  end

  // Array state register.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  // Committed-state reads with address 0 forced to zero.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    rdata3 = '0;
    if (raddr1 != REG_ZERO) begin
      rdata1 = regs_q[raddr1];
    end else begin
      rdata1 = '0;
    end
    if (raddr2 != REG_ZERO) begin
      rdata2 = regs_q[raddr2];
    end else begin
      rdata2 = '0;
    end
    if (raddr3 != REG_ZERO) begin
      rdata3 = regs_q[raddr3];
    end else begin
      rdata3 = '0;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// RV32I writeback stage: result select, register-file commit with write-through bypass
// to the decode read ports, and the retired-instruction counter.
module wb_regfile
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] PCPlus4_w,
  input  logic [DATA_WIDTH-1:0] ALUResult_w,
  input  logic [DATA_WIDTH-1:0] ReadData_w,
  input  logic                  RegWrite_w,
  input  logic [1:0]            ResultSrc_w,
  input  logic [ADDR_WIDTH-1:0] Rd_w,
  input  logic                  valid_w,
  input  logic [ADDR_WIDTH-1:0] rs1_d,
  input  logic [ADDR_WIDTH-1:0] rs2_d,
  output logic [DATA_WIDTH-1:0] rd1_d,
  output logic [DATA_WIDTH-1:0] rd2_d,
  output logic [DATA_WIDTH-1:0] Result_w,
  output logic [CNT_WIDTH-1:0]  instret,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  logic [DATA_WIDTH-1:0] arr_rd1;
  logic [DATA_WIDTH-1:0] arr_rd2;
  logic [DATA_WIDTH-1:0] arr_dbg;
  logic [CNT_WIDTH-1:0]  instret_q;
  logic [CNT_WIDTH-1:0]  instret_d;

  // Writeback result select; the reserved encoding falls back to the ALU result.
  always_comb begin
    case (ResultSrc_w)
      RES_ALU: Result_w = ALUResult_w;
      RES_MEM: Result_w = ReadData_w;
      RES_PC4: Result_w = PCPlus4_w;
      default: Result_w = ALUResult_w;
    endcase
  end

  regfile_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_array (
    .clk   (clk),
    .clr   (~rst_n),
    .we    (RegWrite_w),
    .waddr (Rd_w),
    .wdata (Result_w),
    .raddr1(rs1_d),
    .raddr2(rs2_d),
    .raddr3(dbg_addr),
    .rdata1(arr_rd1),
    .rdata2(arr_rd2),
    .rdata3(arr_dbg)
  );

  // Decode read ports with same-cycle bypass of the commit in flight; debug port sees the array only.
  always_comb begin
    rd1_d    = '0;
    rd2_d    = '0;
    dbg_data = '0;
    if (!rst_n) begin
      rd1_d    = '0;
      rd2_d    = '0;
      dbg_data = '0;
    end else begin
      if (RegWrite_w && (Rd_w == rs1_d) && (rs1_d != REG_ZERO)) begin
        rd1_d = Result_w;
      end else begin
        rd1_d = arr_rd1;
      end
      if (RegWrite_w && (Rd_w == rs2_d) && (rs2_d != REG_ZERO)) begin
        rd2_d = Result_w;
      end else begin
        rd2_d = arr_rd2;
      end
      dbg_data = arr_dbg;
    end
  end

  // Retired-instruction count; wraps silently at the top of its range.
  always_comb begin
    if (!rst_n) begin
      instret_d = '0;
    end else if (valid_w) begin
      instret_d = instret_q + CNT_WIDTH'(1);
    end else begin
      instret_d = instret_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    instret_q <= instret_d;
  end

  assign instret = instret_q;

endmodule
